// File: rtl/fl_arb_pkg.sv
// rtl/fl_arb_pkg.sv - shared types, constants and round-robin pick helper for FrameLink arbiters
package fl_arb_pkg;

  localparam int FL_ARB_CNT_WIDTH = 32;
  localparam int FL_ARB_MAX_PORTS = 16;

  typedef enum logic {IDLE, LOCKED} fl_arb_state_t;

  // First set request at or above ptr, wrapping at ports-1; 0 when nothing is requested.
  function automatic int rr_pick(input logic [FL_ARB_MAX_PORTS-1:0] req,
                                 input logic [3:0] ptr,
                                 input int ports);
    int   pick;
    int   idx;
    logic found;
    pick  = 0;
    found = 1'b0;
    for (int k = 0; k < FL_ARB_MAX_PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= ports) idx = idx - ports;
      if ((k < ports) && !found && req[idx[3:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fl_rr_select.sv
// rtl/fl_rr_select.sv - combinational round-robin picker (req, ptr -> idx, valid)
module fl_rr_select
  import fl_arb_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int SEL_WIDTH = 2
) (
  input  logic [PORTS-1:0]     req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 valid
);

  // Search upward from ptr so the last winner's successor gets first chance.
  always_comb begin
    idx   = SEL_WIDTH'(rr_pick(FL_ARB_MAX_PORTS'(req), 4'(ptr), PORTS));
    valid = |req;
  end

endmodule

// File: rtl/fl_frame_arbiter.sv
// rtl/fl_frame_arbiter.sv - whole-frame round-robin FrameLink arbiter; FL_ARB_FRAME_CNT_EN adds per-port frame counters
module fl_frame_arbiter
  import fl_arb_pkg::*;
#(
  parameter  int PORTS      = 4,
  parameter  int DATA_WIDTH = 64,
  localparam int REM_WIDTH  = $clog2(DATA_WIDTH / 8),
  localparam int SEL_WIDTH  = (PORTS > 2) ? $clog2(PORTS) : 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        ENABLE,
  input  logic [PORTS*DATA_WIDTH-1:0] RX_DATA,
  input  logic [PORTS*REM_WIDTH-1:0]  RX_REM,
  input  logic [PORTS-1:0]            RX_SOF_N,
  input  logic [PORTS-1:0]            RX_EOF_N,
  input  logic [PORTS-1:0]            RX_SOP_N,
  input  logic [PORTS-1:0]            RX_EOP_N,
  input  logic [PORTS-1:0]            RX_SRC_RDY_N,
  output logic [PORTS-1:0]            RX_DST_RDY_N,
  output logic [DATA_WIDTH-1:0]       TX_DATA,
  output logic [REM_WIDTH-1:0]        TX_REM,
  output logic                        TX_SOF_N,
  output logic                        TX_EOF_N,
  output logic                        TX_SOP_N,
  output logic                        TX_EOP_N,
  output logic                        TX_SRC_RDY_N,
  input  logic                        TX_DST_RDY_N,
  output logic [SEL_WIDTH-1:0]        TX_PORT,
  output logic                        BUSY
`ifdef FL_ARB_FRAME_CNT_EN
  ,
  output logic [PORTS*FL_ARB_CNT_WIDTH-1:0] FRAME_CNT,
  input  logic                              CNT_CLR
`endif
);

  fl_arb_state_t        state, state_n;
  logic [SEL_WIDTH-1:0] gnt, gnt_n;
  logic [SEL_WIDTH-1:0] ptr, ptr_n;
  logic [SEL_WIDTH-1:0] pick_idx;
  logic                 pick_valid;
  logic [PORTS-1:0]     req;
  logic                 eof_xfer;

  logic [DATA_WIDTH-1:0] data_a [PORTS];
  logic [REM_WIDTH-1:0]  rem_a  [PORTS];

  for (genvar i = 0; i < PORTS; i++) begin : g_unpack
    assign data_a[i] = RX_DATA[i*DATA_WIDTH +: DATA_WIDTH];
    assign rem_a[i]  = RX_REM[i*REM_WIDTH +: REM_WIDTH];
  end

  // Only a word carrying SOF may open a frame.
  assign req = ~RX_SRC_RDY_N & ~RX_SOF_N;

  fl_rr_select #(
    .PORTS     (PORTS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_rr_select (
    .req   (req),
    .ptr   (ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // Datapath follows the held grant with no register stage.
  always_comb begin
    TX_DATA  = data_a[gnt];
    TX_REM   = rem_a[gnt];
    TX_SOF_N = RX_SOF_N[gnt];
    TX_EOF_N = RX_EOF_N[gnt];
    TX_SOP_N = RX_SOP_N[gnt];
    TX_EOP_N = RX_EOP_N[gnt];
  end

  // Arbitrate in IDLE, pass handshakes of the granted port through in LOCKED until EOF.
  always_comb begin
    state_n      = state;
    gnt_n        = gnt;
    ptr_n        = ptr;
    TX_SRC_RDY_N = 1'b1;
    RX_DST_RDY_N = '1;
    eof_xfer     = 1'b0;
    case (state)
      IDLE: begin
        if (ENABLE && pick_valid) begin
          state_n = LOCKED;
          gnt_n   = pick_idx;
        end
      end
      LOCKED: begin
        TX_SRC_RDY_N      = RX_SRC_RDY_N[gnt];
        RX_DST_RDY_N[gnt] = TX_DST_RDY_N;
        eof_xfer          = ~RX_SRC_RDY_N[gnt] & ~TX_DST_RDY_N & ~RX_EOF_N[gnt];
        if (eof_xfer) begin
          state_n = IDLE;
          ptr_n   = (gnt == SEL_WIDTH'(PORTS - 1)) ? '0 : gnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, grant and rotation pointer registers; reset abandons any partial frame.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
    end else begin
      state <= state_n;
      gnt   <= gnt_n;
      ptr   <= ptr_n;
    end
  end

  assign TX_PORT = gnt;
  assign BUSY    = (state == LOCKED);

`ifdef FL_ARB_FRAME_CNT_EN
  logic [FL_ARB_CNT_WIDTH-1:0] cnt [PORTS];

  // Count completed frames per port; clear takes priority over a same-cycle EOF.
  always_ff @(posedge CLK) begin
    if (!RESET || CNT_CLR) begin
      for (int i = 0; i < PORTS; i++) cnt[i] <= '0;
    end else if (eof_xfer) begin
      cnt[gnt] <= cnt[gnt] + 1'b1;
    end
  end

  for (genvar i = 0; i < PORTS; i++) begin : g_cnt_out
    assign FRAME_CNT[i*FL_ARB_CNT_WIDTH +: FL_ARB_CNT_WIDTH] = cnt[i];
  end
`endif

endmodule

// File: tb/tb_fl_frame_arbiter.sv
// tb/tb_fl_frame_arbiter.sv - self-checking bench for fl_frame_arbiter (FL_ARB_FRAME_CNT_EN optional)
module tb_fl_frame_arbiter;

  localparam int P  = 4;
  localparam int DW = 64;
  localparam int RW = 3;
  localparam int SW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [RW-1:0] rem;
    logic          sof;
    logic          eof;
  } word_t;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            ENABLE;
  logic [P*DW-1:0] RX_DATA;
  logic [P*RW-1:0] RX_REM;
  logic [P-1:0]    RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N, RX_SRC_RDY_N, RX_DST_RDY_N;
  logic [DW-1:0]   TX_DATA;
  logic [RW-1:0]   TX_REM;
  logic            TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N, TX_SRC_RDY_N, TX_DST_RDY_N;
  logic [SW-1:0]   TX_PORT;
  logic            BUSY;
`ifdef FL_ARB_FRAME_CNT_EN
  logic [P*32-1:0] FRAME_CNT;
  logic            CNT_CLR;
`endif

  always #5 CLK = ~CLK;

  fl_frame_arbiter #(.PORTS(P), .DATA_WIDTH(DW)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .RX_DATA      (RX_DATA),
    .RX_REM       (RX_REM),
    .RX_SOF_N     (RX_SOF_N),
    .RX_EOF_N     (RX_EOF_N),
    .RX_SOP_N     (RX_SOP_N),
    .RX_EOP_N     (RX_EOP_N),
    .RX_SRC_RDY_N (RX_SRC_RDY_N),
    .RX_DST_RDY_N (RX_DST_RDY_N),
    .TX_DATA      (TX_DATA),
    .TX_REM       (TX_REM),
    .TX_SOF_N     (TX_SOF_N),
    .TX_EOF_N     (TX_EOF_N),
    .TX_SOP_N     (TX_SOP_N),
    .TX_EOP_N     (TX_EOP_N),
    .TX_SRC_RDY_N (TX_SRC_RDY_N),
    .TX_DST_RDY_N (TX_DST_RDY_N),
    .TX_PORT      (TX_PORT),
    .BUSY         (BUSY)
`ifdef FL_ARB_FRAME_CNT_EN
    ,
    .FRAME_CNT    (FRAME_CNT),
    .CNT_CLR      (CNT_CLR)
`endif
  );

  int          test_cnt = 0;
  int          fail_cnt = 0;
  word_t       fq [P][$];
  int          m_owner = -1;
  int          m_ptr = 0;
  logic [31:0] m_cnt [P];
  int          dut_order [$];
  int          model_order [$];
  int          dut_xfers = 0;
  int          p1_dst_low = 0;
  int          frame_tag = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input int port, input int nwords);
    word_t w;
    frame_tag++;
    for (int i = 0; i < nwords; i++) begin
      w.data = {8'(port), 8'(frame_tag), 16'(i), 32'($urandom)};
      w.rem  = RW'(i);
      w.sof  = (i == 0);
      w.eof  = (i == nwords - 1);
      fq[port].push_back(w);
    end
  endtask

  function automatic logic any_pending();
    for (int i = 0; i < P; i++) if (fq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < P; i++) begin
      if (fq[i].size() > 0) begin
        RX_DATA[i*DW +: DW] = fq[i][0].data;
        RX_REM[i*RW +: RW]  = fq[i][0].rem;
        RX_SOF_N[i]         = ~fq[i][0].sof;
        RX_SOP_N[i]         = ~fq[i][0].sof;
        RX_EOF_N[i]         = ~fq[i][0].eof;
        RX_EOP_N[i]         = ~fq[i][0].eof;
        RX_SRC_RDY_N[i]     = 1'b0;
      end else begin
        RX_DATA[i*DW +: DW] = '0;
        RX_REM[i*RW +: RW]  = '0;
        RX_SOF_N[i]         = 1'b1;
        RX_SOP_N[i]         = 1'b1;
        RX_EOF_N[i]         = 1'b1;
        RX_EOP_N[i]         = 1'b1;
        RX_SRC_RDY_N[i]     = 1'b1;
      end
    end
  endtask

  // Compare DUT against the frame-level model, then advance the model by one clock.
  task automatic compare_and_step();
    logic [P-1:0] exp_dst;
    logic         exp_src;
    logic         xfer;
    logic         eof;
    logic         found;
    int           o;
    int           i;
    o = m_owner;
    exp_dst = '1;
    exp_src = 1'b1;
    if (o >= 0) begin
      exp_src    = (fq[o].size() > 0) ? 1'b0 : 1'b1;
      exp_dst[o] = TX_DST_RDY_N;
    end
    check("busy", 64'(BUSY), (o >= 0) ? 64'd1 : 64'd0);
    check("tx_src_rdy_n", 64'(TX_SRC_RDY_N), 64'(exp_src));
    check("rx_dst_rdy_n", 64'(RX_DST_RDY_N), 64'(exp_dst));
    if (o >= 0 && !exp_src) begin
      check("tx_data", TX_DATA, fq[o][0].data);
      check("tx_rem", 64'(TX_REM), 64'(fq[o][0].rem));
      check("tx_sof_n", 64'(TX_SOF_N), fq[o][0].sof ? 64'd0 : 64'd1);
      check("tx_sop_n", 64'(TX_SOP_N), fq[o][0].sof ? 64'd0 : 64'd1);
      check("tx_eof_n", 64'(TX_EOF_N), fq[o][0].eof ? 64'd0 : 64'd1);
      check("tx_eop_n", 64'(TX_EOP_N), fq[o][0].eof ? 64'd0 : 64'd1);
      check("tx_port", 64'(TX_PORT), 64'(o));
    end
`ifdef FL_ARB_FRAME_CNT_EN
    for (int k = 0; k < P; k++) check("frame_cnt", 64'(FRAME_CNT[k*32 +: 32]), 64'(m_cnt[k]));
`endif
    if (!TX_SRC_RDY_N && !TX_DST_RDY_N) begin
      dut_xfers++;
      if (!TX_SOF_N) dut_order.push_back(int'(TX_PORT));
    end
    if (o == 2 && !RX_DST_RDY_N[1]) p1_dst_low++;

    xfer = (o >= 0) && !exp_src && !TX_DST_RDY_N;
    eof  = xfer && fq[o][0].eof;
    if (xfer) void'(fq[o].pop_front());
    if (!RESET) begin
      m_owner = -1;
      m_ptr   = 0;
`ifdef FL_ARB_FRAME_CNT_EN
      for (int k = 0; k < P; k++) m_cnt[k] = '0;
`endif
    end else begin
`ifdef FL_ARB_FRAME_CNT_EN
      if (CNT_CLR) begin
        for (int k = 0; k < P; k++) m_cnt[k] = '0;
      end else if (eof) begin
        m_cnt[o] = m_cnt[o] + 32'd1;
      end
`endif
      if (o < 0) begin
        found = 1'b0;
        if (ENABLE) begin
          for (int k = 0; k < P; k++) begin
            i = (m_ptr + k) % P;
            if (!found && fq[i].size() > 0 && fq[i][0].sof) begin
              found   = 1'b1;
              m_owner = i;
              model_order.push_back(i);
            end
          end
        end
      end else if (eof) begin
        m_ptr   = (o + 1) % P;
        m_owner = -1;
      end
    end
  endtask

  task automatic tick();
    drive_inputs();
    @(negedge CLK);
    compare_and_step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((any_pending() || m_owner >= 0) && n < max) begin
      tick();
      n++;
    end
    check("drain_within_budget", (n < max) ? 64'd1 : 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    RESET        = 1'b0;
    ENABLE       = 1'b1;
    TX_DST_RDY_N = 1'b0;
`ifdef FL_ARB_FRAME_CNT_EN
    CNT_CLR      = 1'b0;
    for (int k = 0; k < P; k++) m_cnt[k] = '0;
`endif
    drive_inputs();
    @(posedge CLK);
    #1;
    repeat (3) tick();
    RESET = 1'b1;

    // Idle after reset.
    for (int c = 0; c < 20; c++) begin
      tick();
      check("idle_tx_src_rdy_n", 64'(TX_SRC_RDY_N), 64'd1);
      check("idle_busy", 64'(BUSY), 64'd0);
      check("idle_tx_port", 64'(TX_PORT), 64'd0);
    end

    // A word without SOF never wins.
    begin
      word_t w;
      w.data = 64'hdead_beef;
      w.rem  = '0;
      w.sof  = 1'b0;
      w.eof  = 1'b0;
      fq[1].push_back(w);
    end
    repeat (5) begin
      tick();
      check("nosof_busy", 64'(BUSY), 64'd0);
    end
    fq[1].delete();

    // Four simultaneous 3-word frames: strict rotation, one bubble per frame.
    dut_order.delete();
    model_order.delete();
    dut_xfers = 0;
    for (int p = 0; p < P; p++) push_frame(p, 3);
    n = 0;
    while (dut_xfers < 12 && n < 60) begin
      tick();
      n++;
    end
    check("rot_cycles", 64'(n), 64'd16);
    check("rot_xfers", 64'(dut_xfers), 64'd12);
    check("rot_nframes", 64'(dut_order.size()), 64'd4);
    if (dut_order.size() == 4) begin
      check("rot_order0", 64'(dut_order[0]), 64'd0);
      check("rot_order1", 64'(dut_order[1]), 64'd1);
      check("rot_order2", 64'(dut_order[2]), 64'd2);
      check("rot_order3", 64'(dut_order[3]), 64'd3);
    end
    check("rot_model_n", 64'(model_order.size()), 64'd4);
    if (model_order.size() == 4) check("rot_model_last", 64'(model_order[3]), 64'd3);
    drain(10);

    // Port 2 stalled by backpressure while port 1 waits with SOF.
    dut_order.delete();
    dut_xfers  = 0;
    p1_dst_low = 0;
    push_frame(2, 5);
    tick();
    tick();
    TX_DST_RDY_N = 1'b1;
    push_frame(1, 3);
    repeat (3) begin
      tick();
      check("stall_busy", 64'(BUSY), 64'd1);
      check("stall_port", 64'(TX_PORT), 64'd2);
      check("stall_p1_dst", 64'(RX_DST_RDY_N[1]), 64'd1);
    end
    TX_DST_RDY_N = 1'b0;
    drain(40);
    check("stall_p1_never_ready", 64'(p1_dst_low), 64'd0);
    check("stall_xfers", 64'(dut_xfers), 64'd8);
    check("stall_nframes", 64'(dut_order.size()), 64'd2);
    if (dut_order.size() == 2) begin
      check("stall_order0", 64'(dut_order[0]), 64'd2);
      check("stall_order1", 64'(dut_order[1]), 64'd1);
    end

    // ENABLE dropped mid-frame: frame completes, port 3 held off until re-enable.
    push_frame(1, 4);
    tick();
    tick();
    ENABLE = 1'b0;
    push_frame(3, 2);
    repeat (3) tick();
    repeat (5) begin
      tick();
      check("dis_hold_busy", 64'(BUSY), 64'd0);
      check("dis_hold_src", 64'(TX_SRC_RDY_N), 64'd1);
    end
    check("dis_p3_pending", 64'(fq[3].size()), 64'd2);
    ENABLE = 1'b1;
    tick();
    check("en_grant_busy", 64'(BUSY), 64'd1);
    check("en_grant_port", 64'(TX_PORT), 64'd3);
    drain(20);

    // Single-word frame, then reset mid-frame and re-arbitrate.
    push_frame(0, 1);
    tick();
    check("single_busy", 64'(BUSY), 64'd1);
    tick();
    check("single_done", 64'(BUSY), 64'd0);
    push_frame(0, 4);
    repeat (3) tick();
    RESET = 1'b0;
    tick();
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_tx_src", 64'(TX_SRC_RDY_N), 64'd1);
    check("rst_rx_dst", 64'(RX_DST_RDY_N), 64'hf);
    check("rst_tx_port", 64'(TX_PORT), 64'd0);
    RESET = 1'b1;
    fq[0].delete();
    dut_order.delete();
    push_frame(0, 2);
    push_frame(1, 2);
    drain(30);
    check("rst_nframes", 64'(dut_order.size()), 64'd2);
    if (dut_order.size() == 2) begin
      check("rst_order0", 64'(dut_order[0]), 64'd0);
      check("rst_order1", 64'(dut_order[1]), 64'd1);
    end

`ifdef FL_ARB_FRAME_CNT_EN
    // Frame counters: seven frames on port 3, then clear coinciding with EOF.
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    check("cnt_cleared", 64'(FRAME_CNT[3*32 +: 32]), 64'd0);
    for (int f = 0; f < 7; f++) push_frame(3, 2);
    drain(100);
    check("cnt_p3_seven", 64'(FRAME_CNT[3*32 +: 32]), 64'd7);
    check("cnt_model_seven", 64'(m_cnt[3]), 64'd7);
    check("cnt_p0_zero", 64'(FRAME_CNT[0 +: 32]), 64'd0);
    push_frame(3, 1);
    tick();
    CNT_CLR = 1'b1;
    tick();
    CNT_CLR = 1'b0;
    check("cnt_clr_wins", 64'(FRAME_CNT[3*32 +: 32]), 64'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/fl_frame_arbiter.md
Name: fl_frame_arbiter

Overview:
- Round-robin arbiter that shares one netcope adder FrameLink input between PORTS FrameLink sources, at whole-frame granularity.
- Once a frame starts, the grant is locked from SOF to EOF, so frames are never interleaved.
- Outputs the winning port index alongside the frame, so the netcope adder can stamp a source ID.
- Sits directly in front of the netcope adder; the enable input lets software pause the adder path between frames.

Parameters:
- PORTS, 4, number of FrameLink input ports (2..16).
- DATA_WIDTH, 64, FrameLink data width in bits (multiple of 8).
- REM_WIDTH, derived localparam = log2(DATA_WIDTH/8), width of REM.
- SEL_WIDTH, derived localparam = max(1, log2(PORTS)), width of the port index.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous reset, active-low.
- ENABLE  in  1  1 = new grants allowed; 0 = finish the current frame, then hold.
- RX_DATA  in  PORTS*DATA_WIDTH  input data, flattened; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- RX_REM  in  PORTS*REM_WIDTH  input remainder, flattened.
- RX_SOF_N, RX_EOF_N, RX_SOP_N, RX_EOP_N  in  PORTS  input FrameLink delimiters, active-low.
- RX_SRC_RDY_N  in  PORTS  input source ready, active-low.
- RX_DST_RDY_N  out  PORTS  input destination ready, active-low.
- TX_DATA  out  DATA_WIDTH  muxed output data.
- TX_REM  out  REM_WIDTH  muxed output remainder.
- TX_SOF_N, TX_EOF_N, TX_SOP_N, TX_EOP_N  out  1  muxed output delimiters.
- TX_SRC_RDY_N  out  1  output source ready, active-low.
- TX_DST_RDY_N  in  1  output destination ready, active-low.
- TX_PORT  out  SEL_WIDTH  index of the granted port; valid while TX_SRC_RDY_N=0.
- BUSY  out  1  high while a grant is locked.

Behaviour:
- Reset values: TX_SRC_RDY_N=1, RX_DST_RDY_N all 1, TX_PORT=0, BUSY=0, RR pointer=0, state=IDLE.
- Transfer on port x occurs in a cycle where SRC_RDY_N=0 and DST_RDY_N=0 on that port.
- FSM state IDLE:
  - Request vector req[i] = ~RX_SRC_RDY_N[i] & ~RX_SOF_N[i].
  - If ENABLE=1 and any req is set, choose the first set bit searching upward from ptr, wrapping at PORTS-1 to 0.
  - Register the winner into gnt (and TX_PORT), then go to LOCKED.
  - No RX/TX handshake happens in IDLE: TX_SRC_RDY_N=1, all RX_DST_RDY_N=1.
- FSM state LOCKED:
  - TX_DATA, TX_REM and all delimiters mux from port gnt, combinationally.
  - TX_SRC_RDY_N = RX_SRC_RDY_N[gnt].
  - RX_DST_RDY_N[gnt] = TX_DST_RDY_N; all other ports are held at 1.
  - On a transfer with TX_EOF_N=0: set ptr = (gnt+1) mod PORTS, then go to IDLE.
- Latency:
  - Zero combinational latency through the datapath.
  - One arbitration cycle (IDLE) before every frame, so back-to-back frames cost 1 bubble cycle.
- Single-word frame (SOF and EOF in the same word): one cycle in LOCKED, then return to IDLE.
- Requests without SOF (protocol violation) are ignored; that port never wins until it presents SOF.
- ENABLE falling during LOCKED: the current frame completes normally; IDLE then holds with no grant.
- ENABLE is sampled only in IDLE.
- All requesters active: strict rotation 0,1,2,3,0,…
- Lone requester: wins every arbitration; the pointer still advances.
- Backpressure: TX_DST_RDY_N=1 stalls the granted port only; the grant stays held indefinitely.
- Reset asserted mid-frame:
  - Next edge forces IDLE and ptr=0; all ready outputs deassert.
  - The partial frame is abandoned; no recovery is attempted.
- BUSY = (state==LOCKED).

Optional Feature:
- Macro FL_ARB_FRAME_CNT_EN.
- When defined:
  - Adds output FRAME_CNT (PORTS*32 bits) and input CNT_CLR (1 bit).
  - Per-port counter increments on each EOF transfer granted to that port and wraps at 2^32-1 → 0.
  - CNT_CLR=1 zeroes all counters synchronously; a clear wins over a simultaneous increment.
  - Counters reset to 0.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package fl_arb_pkg holds:
  - typedef enum logic {IDLE, LOCKED} fl_arb_state_t;
  - function rr_pick(req, ptr) returning the index;
  - constant FL_ARB_CNT_WIDTH=32.
- Sub-module fl_rr_select: a combinational round-robin picker (req, ptr → idx, valid), reusable by other FL arbiters.
- Datapath mux and FSM stay in the top module.

Test Plan:
- Reset then idle, all SRC_RDY_N=1 → TX_SRC_RDY_N=1, BUSY=0, TX_PORT=0 for 20 cycles.
- Ports 0..3 each present one 3-word frame simultaneously, TX_DST_RDY_N=0 → output frames in order 0,1,2,3 with TX_PORT matching; 12 data cycles plus 4 IDLE cycles; no interleaving.
- Port 2 sends a 5-word frame; TX_DST_RDY_N=1 on words 2-3 → port 2 stalls; port 1 with a pending SOF receives RX_DST_RDY_N=1 throughout; data arrives intact.
- ENABLE dropped on word 1 of a 4-word frame from port 1 → frame finishes; port 3 request is held off until ENABLE=1, then granted on the next cycle.
- RESET=0 mid-frame on port 0, then port 0 and port 1 request → ptr=0, so port 0 wins the first arbitration after reset.
- With FL_ARB_FRAME_CNT_EN: 7 frames from port 3 → FRAME_CNT[3]=7; CNT_CLR pulsed on the same cycle as an EOF → counter reads 0.
